rr_bus_arbiter_8: RTL and testbench
===================================

Name: rr_bus_arbiter_8

Overview:
- Shares one 32-bit result bus between 8 requesters (e.g. ALU, multdiv, memory, CSR units) using round-robin arbitration.
- Drives the 3-bit select of an internal mux_8 instance and captures the winning word into a one-deep output register.
- The output register has a valid/ready handshake toward the consumer, such as the register-file writeback stage.
- Supports locked bursts with a bounded length to avoid starvation.

Parameters:
- WIDTH, 32, data width of each requester word (mux_8 is fixed at 32; WIDTH other than 32 is illegal).
- MAX_BURST, 4, maximum consecutive grants to one locked requester (range 1..15).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  8  request per source; held with its data until ack
- lock  in  8  per-source burst lock; sampled only from the currently granted source
- data_in  in  8*WIDTH  packed source words; source i occupies [i*WIDTH +: WIDTH]
- ack  out  8  one-hot, combinational; high in the cycle source i's word is captured
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts a word when out_valid && out_ready
- out_data  out  WIDTH  captured word
- out_src  out  3  index of the source that produced out_data

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=7, so source 0 has first priority.
  - state=ARB, burst_cnt=0. ack is 0 while in reset.
- load = (|req) && (!out_valid || out_ready). The output register accepts a new word only on load.
- Pick (combinational) in state ARB:
  - First asserted req scanning last_grant+1, +2, ... modulo 8.
  - The pick index is the mux_8 select.
- On load in ARB:
  - out_data <= mux_8 output; out_src <= pick; out_valid <= 1; ack[pick]=1; last_grant <= pick.
  - If lock[pick] && MAX_BURST>1: state <= LOCKED, burst_cnt <= 1.
- State LOCKED (owner = last_grant):
  - The select is forced to the owner, and only req[owner] can load.
  - On load: capture as above, ack[owner]=1, burst_cnt++.
  - Return to ARB in the same edge if lock[owner]==0 or burst_cnt+1==MAX_BURST.
  - If req[owner]==0 or lock[owner]==0 while not loading: return to ARB next edge with no capture. Other requests are not served that cycle.
- Drain without load (out_valid && out_ready && no eligible req): out_valid <= 0, and out_data/out_src hold their values.
- Simultaneous drain and load: the new word replaces the old one and out_valid stays 1. This gives full throughput of 1 word/cycle.
- Backpressure (out_valid && !out_ready): no load and no ack. out_data and out_src are stable. last_grant, state and burst_cnt are frozen.
- Wrap-around: the pointer is modulo-8. After a grant to 7, source 0 has top priority.
- Fairness bound: an asserted, unlocked-contention req is acked within 7 loads, plus MAX_BURST-1 loads if a locked burst is in progress.
- Invalid inputs: lock on a non-granted source is ignored. Deasserting req without ack is allowed; that request is simply dropped.
- Reset mid-burst: returns immediately to the reset values above, and any in-flight out_data is discarded.

Decomposition:
- Shared package: ARB=1'b0 and LOCKED=1'b1 state encodings, plus the NUM_SRC=8 and SRC_W=3 constants.
- Sub-module rr_pick8:
  - Inputs: req[7:0], last[2:0].
  - Outputs: idx[2:0], any.
  - Implemented as a rotate, priority-encode, un-rotate structure.
- Datapath: reuse the existing mux_8, with select = state==LOCKED ? last_grant : idx.

Test Plan:
- Reset then req=8'b0000_0001, data0=32'hDEADBEEF, out_ready=1 -> ack=0x01 in cycle 1; next cycle out_valid=1, out_data=DEADBEEF, out_src=0.
- All 8 req held, out_ready=1, no lock -> out_src sequence 0,1,2,...,7,0 with one word/cycle and ack one-hot each cycle.
- req=0x81 with last_grant=7 -> source 0 first, then 7, then 0 (wrap-around priority).
- req[2]=1, lock[2]=1, req[5]=1, MAX_BURST=4 -> out_src 2,2,2,2,5; ack[5] is withheld until the 4th grant to source 2.
- out_ready=0 for 5 cycles with req[3]=1 -> out_data stable, ack=0 throughout; first cycle out_ready=1 -> old word drains, source 3 captured, ack[3]=1.
- Assert reset mid-LOCKED burst -> out_valid=0 and ack=0 asynchronously; after release, source 0 has priority.

Source files
------------

// File: rtl/rr_bus_arbiter_8_pkg.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter_8_pkg
// Shared constants and the arbiter state encoding. Every rr_bus_arbiter_8
// file imports this package.
//   NUM_SRC : number of requesters sharing the result bus
//   SRC_W   : width of a source index
//   state_e : ARB (free round-robin) / LOCKED (burst owner holds the bus)
// ---------------------------------------------------------------------------
package rr_bus_arbiter_8_pkg;

    localparam int NUM_SRC = 8;
    localparam int SRC_W   = 3;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rr_bus_arbiter_8_if.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter_8_if
// Groups the requester side and the consumer side of the arbiter.
//   req/lock/data_in : per-source request, burst lock and packed data words
//   ack              : one-hot, high in the cycle a source's word is captured
//   out_valid/out_ready/out_data/out_src : output register handshake
// Modports:
//   master : the environment (requesters plus consumer)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface rr_bus_arbiter_8_if
    import rr_bus_arbiter_8_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0]       lock;
    logic [NUM_SRC*WIDTH-1:0] data_in;
    logic [NUM_SRC-1:0]       ack;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SRC_W-1:0]         out_src;

    modport master (
        output req, lock, data_in, out_ready,
        input  ack, out_valid, out_data, out_src
    );

    modport slave (
        input  req, lock, data_in, out_ready,
        output ack, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux_8.sv
// ---------------------------------------------------------------------------
// mux_8
// Fixed 32-bit, 8-input multiplexer used on the shared result bus.
//   in0..in7 : candidate words
//   sel      : 3-bit select
//   out      : selected word
// ---------------------------------------------------------------------------
module mux_8 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    input  logic [31:0] in5,
    input  logic [31:0] in6,
    input  logic [31:0] in7,
    input  logic [2:0]  sel,
    output logic [31:0] out
);

    // Plain case-based selection; synthesizes to a balanced mux tree.
    always_comb begin
        out = in0;
        case (sel)
            3'd0: out = in0;
            3'd1: out = in1;
            3'd2: out = in2;
            3'd3: out = in3;
            3'd4: out = in4;
            3'd5: out = in5;
            3'd6: out = in6;
            3'd7: out = in7;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter_8_rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Round-robin pick among 8 requests.
//   req  : request vector
//   last : index of the most recent grant; scanning starts at last+1
//   idx  : first asserted request found scanning last+1, last+2, ... mod 8
//   any  : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick8
    import rr_bus_arbiter_8_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   idx,
    output logic               any
);

    logic [SRC_W-1:0]   start;
    logic [NUM_SRC-1:0] rotated;
    logic [SRC_W-1:0]   offset;

    // Rotate so the highest-priority source sits at bit 0, take the lowest
    // set bit, then add the rotation back to recover the real index.
    always_comb begin
        start   = last + 3'd1;
        rotated = '0;
        offset  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rotated[i] = req[start + i[SRC_W-1:0]];
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i[SRC_W-1:0];
            end
        end
        idx = start + offset;
        any = |req;
    end

endmodule

// File: rtl/rr_bus_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter_8
// Shares one 32-bit result bus among 8 requesters with round-robin priority,
// optional locked bursts (bounded by MAX_BURST) and a one-deep output
// register with a valid/ready handshake toward the consumer.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : rr_bus_arbiter_8_if.slave (req, lock, data_in, ack, out_valid,
//           out_ready, out_data, out_src)
// WIDTH must be 32 because mux_8 is fixed at 32 bits. MAX_BURST is 1..15.
// ---------------------------------------------------------------------------
module rr_bus_arbiter_8
    import rr_bus_arbiter_8_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
)(
    input  logic               clock,
    input  logic               reset,
    rr_bus_arbiter_8_if.slave  bus
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    state_e             state_q,      state_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [3:0]         burst_cnt_q,  burst_cnt_d;
    logic               out_valid_q,  out_valid_d;
    logic [WIDTH-1:0]   out_data_q,   out_data_d;
    logic [SRC_W-1:0]   out_src_q,    out_src_d;

    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic [SRC_W-1:0]   sel;
    logic [WIDTH-1:0]   mux_out;
    logic               can_accept;
    logic               eligible;
    logic               load;

    rr_pick8 u_pick (
        .req  (bus.req),
        .last (last_grant_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    mux_8 u_mux (
        .in0 (bus.data_in[0*WIDTH +: WIDTH]),
        .in1 (bus.data_in[1*WIDTH +: WIDTH]),
        .in2 (bus.data_in[2*WIDTH +: WIDTH]),
        .in3 (bus.data_in[3*WIDTH +: WIDTH]),
        .in4 (bus.data_in[4*WIDTH +: WIDTH]),
        .in5 (bus.data_in[5*WIDTH +: WIDTH]),
        .in6 (bus.data_in[6*WIDTH +: WIDTH]),
        .in7 (bus.data_in[7*WIDTH +: WIDTH]),
        .sel (sel),
        .out (mux_out)
    );

    // Work out which source owns the mux this cycle and whether its word
    // is captured. In LOCKED only the burst owner may load. The ack is gated
    // by reset so nothing is acknowledged while the block is held in reset.
    always_comb begin
        can_accept = !out_valid_q || bus.out_ready;
        if (state_q == LOCKED) begin
            sel      = last_grant_q;
            eligible = bus.req[last_grant_q];
        end else begin
            sel      = pick_idx;
            eligible = pick_any;
        end
        load    = eligible && can_accept;
        bus.ack = (load && reset) ? (8'd1 << sel) : 8'd0;
    end

    // Next-state for the arbitration FSM, the round-robin pointer, the burst
    // counter and the output register. Everything holds by default, which is
    // exactly what backpressure needs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;

        if (load) begin
            out_data_d   = mux_out;
            out_src_d    = sel;
            out_valid_d  = 1'b1;
            last_grant_d = sel;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (load && bus.lock[sel] && (MAX_BURST > 1)) begin
                    state_d     = LOCKED;
                    burst_cnt_d = 4'd1;
                end
            end
            LOCKED: begin
                if (load) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (!bus.lock[last_grant_q] ||
                        (burst_cnt_q + 4'd1 == MAX_BURST_C)) begin
                        state_d     = ARB;
                        burst_cnt_d = 4'd0;
                    end
                end else if (can_accept &&
                             (!bus.req[last_grant_q] || !bus.lock[last_grant_q])) begin
                    // Owner gave up the bus; nobody else is served this cycle.
                    state_d     = ARB;
                    burst_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d     = ARB;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    // State register. Reset puts the pointer at 7 so source 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB;
            last_grant_q <= 3'd7;
            burst_cnt_q  <= 4'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_bus_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_rr_bus_arbiter_8
// Directed bench for rr_bus_arbiter_8 (WIDTH=32, MAX_BURST=4). Each step
// drives inputs, checks the combinational ack, clocks once and checks the
// output register against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rr_bus_arbiter_8;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    rr_bus_arbiter_8_if #(.WIDTH(32)) bus_if ();

    rr_bus_arbiter_8 #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] wordOf(input int i);
        return (i == 0) ? 32'hDEADBEEF : (32'hC0DE_0000 + 32'(i) * 32'h111);
    endfunction

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l,
                                 input logic rdy);
        bus_if.req       = r;
        bus_if.lock      = l;
        bus_if.out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkAck(input string tag, input logic [7:0] expected);
        #1;
        checkOutput(tag, {24'd0, bus_if.ack}, {24'd0, expected});
    endtask

    task automatic checkReg(input string tag, input logic v, input int src);
        checkOutput({tag, "_valid"}, {31'd0, bus_if.out_valid}, {31'd0, v});
        checkOutput({tag, "_src"}, {29'd0, bus_if.out_src}, 32'(src));
        checkOutput({tag, "_data"}, bus_if.out_data, wordOf(src));
    endtask

    initial begin
        int expSeq[5];
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_if.data_in[i*32 +: 32] = wordOf(i);
        end
        applyStimulus(8'h01, 8'h00, 1'b1);
        #12;

        // Reset values, with a request already pending.
        checkOutput("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        checkOutput("rst_data", bus_if.out_data, 32'd0);
        checkOutput("rst_src", {29'd0, bus_if.out_src}, 32'd0);
        checkOutput("rst_ack", {24'd0, bus_if.ack}, 32'd0);

        // Single request from source 0.
        @(negedge clock);
        reset = 1'b1;
        checkAck("t1_ack", 8'h01);
        tick();
        checkReg("t1", 1'b1, 0);
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkAck("t1_idle_ack", 8'h00);
        tick();
        checkReg("t1_drain", 1'b0, 0);

        // All requests: pointer is at 0, so 1,2,...,7,0,1 at one word/cycle.
        applyStimulus(8'hFF, 8'h00, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checkAck("t2_ack", 8'd1 << ((k + 1) % 8));
            tick();
            checkReg("t2", 1'b1, (k + 1) % 8);
        end
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("t2_drain", {31'd0, bus_if.out_valid}, 32'd0);

        // Wrap-around: grant 7, then 0x81 gives 0, 7, 0.
        applyStimulus(8'h80, 8'h00, 1'b1);
        checkAck("t3_ack7", 8'h80);
        tick();
        checkReg("t3_first", 1'b1, 7);
        applyStimulus(8'h81, 8'h00, 1'b1);
        expSeq = '{0, 7, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            checkAck("t3_ack", 8'd1 << expSeq[k]);
            tick();
            checkReg("t3", 1'b1, expSeq[k]);
        end
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();

        // Locked burst from 2 with 5 also requesting: 2,2,2,2,5.
        applyStimulus(8'h24, 8'h04, 1'b1);
        expSeq = '{2, 2, 2, 2, 5};
        for (int k = 0; k < 5; k++) begin
            checkAck("t4_ack", 8'd1 << expSeq[k]);
            tick();
            checkReg("t4", 1'b1, expSeq[k]);
        end
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();

        // Backpressure: capture 6 with out_ready low, then hold 5 cycles.
        applyStimulus(8'h40, 8'h00, 1'b0);
        checkAck("t5_ack6", 8'h40);
        tick();
        checkReg("t5_load", 1'b1, 6);
        applyStimulus(8'h08, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkAck("t5_stall_ack", 8'h00);
            tick();
            checkReg("t5_stall", 1'b1, 6);
        end
        applyStimulus(8'h08, 8'h00, 1'b1);
        checkAck("t5_ack3", 8'h08);
        tick();
        checkReg("t5_release", 1'b1, 3);
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();

        // Locked owner 4 drops its request: bus idles one cycle, then 5.
        applyStimulus(8'h30, 8'h10, 1'b1);
        checkAck("t6_ack4", 8'h10);
        tick();
        checkReg("t6_lock", 1'b1, 4);
        applyStimulus(8'h20, 8'h10, 1'b1);
        checkAck("t6_gap_ack", 8'h00);
        tick();
        checkReg("t6_gap", 1'b0, 4);
        checkAck("t6_ack5", 8'h20);
        tick();
        checkReg("t6_next", 1'b1, 5);
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();

        // Reset in the middle of a locked burst from source 1.
        applyStimulus(8'h02, 8'h02, 1'b1);
        checkAck("t7_ack1a", 8'h02);
        tick();
        checkReg("t7_b1", 1'b1, 1);
        checkAck("t7_ack1b", 8'h02);
        tick();
        checkReg("t7_b2", 1'b1, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t7_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        checkOutput("t7_rst_ack", {24'd0, bus_if.ack}, 32'd0);
        checkOutput("t7_rst_data", bus_if.out_data, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(8'h81, 8'h00, 1'b1);
        checkAck("t7_ack0", 8'h01);
        tick();
        checkReg("t7_after", 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
